// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the bus, decodes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) and flags framing/timeout errors.
module ps2_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

  state_e                state_q, state_d;
  logic                  clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [8:0]            shift_q, shift_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_err_q, rx_err_d;
  logic                  bit_evt, tmo_hit, frame_ok;

  // Filtered level moves only once the whole sample history agrees.
  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], clk_s2_q};
    filt_d = filt_q;
    if (&hist_q) begin
      filt_d = 1'b1;
    end else if (hist_q == '0) begin
      filt_d = 1'b0;
    end
  end

  assign bit_evt  = filt_q & ~filt_d;
  assign tmo_hit  = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
  // Stop bit must be 1 and data+parity must hold an odd number of ones.
  assign frame_ok = data_s2_q & (^shift_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bit_evt && !data_s2_q) state_d = StData;
      StData: begin
        if (bit_evt) begin
          if (bit_cnt_q == 4'd8) state_d = StStop;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      StStop: if (bit_evt || tmo_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q != StIdle);
    rx_data  = rx_data_q;
    rx_valid = rx_valid_q;
    rx_err   = rx_err_q;
  end

  // Datapath next-state: bit events always take priority over the timeout.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tmo_d      = tmo_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (bit_evt && !data_s2_q) begin
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      StData: begin
        if (bit_evt) begin
          shift_d   = {data_s2_q, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          tmo_d     = '0;
        end else if (tmo_hit) begin
          tmo_d    = '0;
          rx_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StStop: begin
        if (bit_evt) begin
          tmo_d = '0;
          if (frame_ok) begin
            rx_data_d  = shift_q[7:0];
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end else if (tmo_hit) begin
          tmo_d    = '0;
          rx_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: tmo_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      hist_q     <= '1;
      filt_q     <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
      hist_q     <= hist_d;
      filt_q     <= filt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: good frames, parity/stop errors, timeout, glitch and mid-frame reset.
module tb_ps2_rx;

  localparam int unsigned Filt = 8;
  localparam int unsigned Tmo  = 200;
  localparam int          Half = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] last_data = 8'h00;

  ps2_rx #(
    .FILTER_LEN (Filt),
    .TIMEOUT_CYC(Tmo)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_data = rx_data;
    end
    if (rx_err) err_cnt++;
    if (rx_valid && rx_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first n bits of an 11-bit frame vector, LSB (start bit) first.
  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(Half - 13);
      end else begin
        wait_cyc(Half);
      end
      ps2_clk = 1'b0;
      wait_cyc(Half);
      ps2_clk = 1'b1;
    end
  endtask

  // Full frame; lat = cycles from the stop-bit fall to the first rx_valid/rx_err (-1 if none).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int glitch_bit, output int lat);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    send_bits(bits, 10, glitch_bit);
    ps2_data = s;
    wait_cyc(Half);
    ps2_clk = 1'b0;
    lat = -1;
    for (int k = 1; k <= Half; k++) begin
      wait_cyc(1);
      if (lat < 0 && (rx_valid || rx_err)) lat = k;
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(Half);
  endtask

  initial begin
    int lat;
    int n;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_rx_err", 32'(rx_err), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);
    chk("no_event_after_reset", 32'(valid_cnt + err_cnt), 32'd0);

    // 0x1C, odd parity 0, stop 1
    send_frame(8'h1C, 1'b0, 1'b1, -1, lat);
    chk("f1c_latency", 32'(lat), 32'd11);
    chk("f1c_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("f1c_err_cnt", 32'(err_cnt), 32'd0);
    chk("f1c_rx_data", 32'(rx_data), 32'h1C);
    chk("f1c_busy_after", 32'(busy), 32'h0);

    send_frame(8'hF0, 1'b1, 1'b1, -1, lat);
    chk("ff0_data", 32'(last_data), 32'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, -1, lat);
    chk("b2b_data", 32'(last_data), 32'h1C);
    chk("b2b_valid_cnt", 32'(valid_cnt), 32'd3);

    // Bad parity
    send_frame(8'h1C, 1'b1, 1'b1, -1, lat);
    chk("par_latency", 32'(lat), 32'd11);
    chk("par_err_cnt", 32'(err_cnt), 32'd1);
    chk("par_valid_cnt", 32'(valid_cnt), 32'd3);
    chk("par_rx_data_held", 32'(rx_data), 32'h1C);

    // Stop bit 0
    send_frame(8'h29, 1'b0, 1'b0, -1, lat);
    chk("stop_err_cnt", 32'(err_cnt), 32'd2);
    chk("stop_rx_data_held", 32'(rx_data), 32'h1C);

    // Timeout: start + 3 data bits, then a 4th whose fall is the last event
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 4, -1);
    ps2_data = 1'b1;
    wait_cyc(Half);
    ps2_clk = 1'b0;
    n = 0;
    while (!rx_err && n < 400) begin
      wait_cyc(1);
      n++;
      if (n == Half) ps2_clk = 1'b1;
    end
    chk("tmo_cycles", 32'(n), 32'(Tmo + 11));
    chk("tmo_busy_drop", 32'(busy), 32'h0);
    wait_cyc(5);
    chk("tmo_err_cnt", 32'(err_cnt), 32'd3);
    send_frame(8'h29, 1'b0, 1'b1, -1, lat);
    chk("post_tmo_data", 32'(last_data), 32'h29);
    chk("post_tmo_valid_cnt", 32'(valid_cnt), 32'd4);

    // 0x5A (four ones, parity 1) with a 3-cycle clock glitch before data bit 3
    send_frame(8'h5A, 1'b1, 1'b1, 4, lat);
    chk("glitch_data", 32'(rx_data), 32'h5A);
    chk("glitch_valid_cnt", 32'(valid_cnt), 32'd5);
    chk("glitch_err_cnt", 32'(err_cnt), 32'd3);

    // Reset after start + 4 data bits
    send_bits({1'b1, 1'b0, 8'hFF, 1'b0}, 5, -1);
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n    = 1'b1;
    ps2_data = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_data", 32'(rx_data), 32'h00);
    wait_cyc(Tmo + 50);
    chk("mid_rst_no_pulse", 32'(valid_cnt + err_cnt), 32'd8);
    send_frame(8'h29, 1'b0, 1'b1, -1, lat);
    chk("mid_rst_next_data", 32'(rx_data), 32'h29);
    chk("mid_rst_next_valid", 32'(valid_cnt), 32'd6);

    chk("valid_err_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive equal synchronized ps2_clk samples needed to change the filtered clock level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000 (2 ms at 50 MHz): maximum number of cycles allowed between filtered falling edges inside a frame.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, 50 MHz.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1 bit: raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port rx_data, output, 8 bits: last correctly received scan-code byte.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle pulse, high when rx_data has just been updated.
REQ-009 SHALL have port rx_err, output, 1 bit: one-cycle pulse, high on a parity, stop-bit or timeout error.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is in progress.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; both flops of each synchronizer reset to 1.
REQ-012 Filtered clock level SHALL change only after the last FILTER_LEN synchronized ps2_clk samples all equal the new value; it resets to 1.
REQ-013 A bit event SHALL be the cycle in which the filtered clock goes 1->0; on that cycle the synchronized ps2_data value is sampled.
REQ-014 The FSM SHALL have three states, IDLE, DATA and STOP, and reset to IDLE.
REQ-015 IDLE: a bit event with sampled data 0 (start bit) -> DATA with bit count 0; a bit event with data 1 -> stay in IDLE, no pulse.
REQ-016 DATA: each bit event shifts in one bit, LSB first; after 9 bits (8 data + parity) -> STOP.
REQ-017 STOP: the next bit event ends the frame and the FSM returns to IDLE.
REQ-018 End of frame with stop bit 1 and odd parity (XOR of 8 data bits and the parity bit = 1): rx_data SHALL load the byte and rx_valid SHALL pulse, both on the cycle after the stop-bit event.
REQ-019 End of frame with stop bit 0 or bad parity: rx_err SHALL pulse on the cycle after the stop-bit event; rx_data is unchanged.
REQ-020 A timeout counter SHALL clear on every bit event and count in DATA/STOP; reaching TIMEOUT_CYC -> IDLE and a one-cycle rx_err pulse.
REQ-021 If a bit event and the timeout terminal count occur in the same cycle, the bit event wins: the counter clears and no error is raised.
REQ-022 rx_valid and rx_err SHALL never be high in the same cycle.
REQ-023 busy SHALL be 1 in DATA and STOP, and 0 in IDLE.
REQ-024 rx_data SHALL hold its value between valid frames.
REQ-025 A filtered falling edge right after reset SHALL be impossible, because the filter state resets to the bus idle level of 1.

Reset
REQ-026 rst_n low at a rising edge of clk SHALL return every block to its reset state:
- FSM to IDLE, bit count and shift register to 0, timeout counter to 0.
- rx_data = 0x00, rx_valid = 0, rx_err = 0, busy = 0.
- Synchronizers and filter to 1.
REQ-027 A reset asserted mid-frame SHALL abort the frame with no rx_valid and no rx_err pulse; the next complete frame SHALL be received normally.

Verification
REQ-028 Frame 0x1C, parity 0, stop 1, ps2_clk period 80 us -> exactly one rx_valid pulse, rx_data = 0x1C, no rx_err.
REQ-029 Frames 0xF0 (parity 1) then 0x1C (parity 0) back-to-back -> two rx_valid pulses; rx_data reads 0xF0, then 0x1C.
REQ-030 Frame 0x1C with parity 1 -> one rx_err pulse, no rx_valid, rx_data keeps its previous value.
REQ-031 Start bit plus 4 data bits, then ps2_clk held high -> rx_err pulses TIMEOUT_CYC cycles after the last event; busy drops at the same time; the following frame 0x29 is received correctly.
REQ-032 A 3-cycle low glitch on ps2_clk inside a frame (FILTER_LEN = 8) -> no extra bit counted; the frame decodes correctly.
REQ-033 rst_n pulsed low for 2 cycles after 4 bits of a frame -> no pulse for that frame; the next frame 0x29 gives rx_valid with rx_data = 0x29.
